voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter ADDR_W, default 20: sample SRAM address width.
REQ-002 Parameter KEY_W, default 8: key code width.
REQ-003 Clock and reset: single clock Clk; Reset is synchronous, active-high.
REQ-004 Clk  input  1  system clock; all state updates on posedge.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 sample_clk  input  1  audio sample-rate clock, synchronous to Clk, high and low phases each at least 8 Clk.
REQ-007 key_req  input  1  key event request, held high until key_ack.
REQ-008 key_on  input  1  event type with key_req: 1 = note-on, 0 = note-off.
REQ-009 key_code  input  KEY_W  key identifier.
REQ-010 key_base  input  ADDR_W  first sample address for the key (note-on only).
REQ-011 key_len  input  ADDR_W  sample length in words, at least 1 (note-on only).
REQ-012 key_ack  output  1  one-cycle pulse when the event is consumed.
REQ-013 voice_addr0..voice_addr3  output  ADDR_W each  current read address per voice.
REQ-014 voice_active  output  4  per-voice playing flag.
REQ-015 addr_sel  output  2  active voice count minus 1, floored at 0, to the multinote fetch controller.

Function
REQ-016 FSM states: IDLE, ADVANCE, ALLOC, RELEASE.
REQ-017 Rising-edge detect on sample_clk: register the previous value; an edge sets adv_pend.
REQ-018 IDLE transitions: adv_pend goes to ADVANCE; else key_req with key_on=1 goes to ALLOC; else key_req with key_on=0 goes to RELEASE; else IDLE.
REQ-019 adv_pend has priority over key_req; key_req stays pending, never dropped.
REQ-020 ADVANCE (1 cycle): for each active voice, if addr equals end address, clear active; else addr += 1; clear adv_pend; return to IDLE.
REQ-021 End address per voice is key_base + key_len - 1, computed modulo 2^ADDR_W and stored at allocation; address wrap past all-ones follows the same modulo.
REQ-022 ALLOC (1 cycle) voice selection, first match wins:
  - an active voice with the same key_code (retrigger);
  - else the lowest-index inactive voice;
  - else the voice with the highest age, ties to the lowest index (steal).
REQ-023 On ALLOC the chosen voice gets addr = key_base, stored key, stored end address, active = 1, age = 0; every other active voice increments age, saturating at 3.
REQ-024 key_ack pulses in the ALLOC cycle and in the RELEASE cycle; the FSM returns to IDLE next.
REQ-025 RELEASE (1 cycle): clear active for every voice whose stored key equals key_code; no match means no state change but key_ack still pulses.
REQ-026 A sample_clk edge arriving during ALLOC or RELEASE is latched in adv_pend and serviced from the next IDLE.
REQ-027 A new event is accepted no earlier than the IDLE cycle after key_ack; key_req still high in that cycle is treated as a new event.
REQ-028 Outputs are registered; updated voice_addr, voice_active and addr_sel are visible the cycle after ADVANCE, ALLOC or RELEASE.
REQ-029 addr_sel = popcount(voice_active) - 1, floored at 0 (0 or 1 active gives 0; 4 active gives 3).
REQ-030 An inactive voice keeps its voice_addr value.
REQ-031 Maximum event latency from key_req to key_ack is 3 cycles.

Reset
REQ-032 Reset forces state to IDLE, adv_pend to 0, the sample_clk edge register to 0, and all voice_active bits to 0.
REQ-033 Reset forces all voice_addr, stored keys, end addresses and ages to 0.
REQ-034 Reset forces key_ack and addr_sel to 0.
REQ-035 Reset mid-ALLOC or mid-RELEASE aborts the event with no key_ack; the requester re-presents key_req.

Verification
REQ-036 Note-on key 0x3C, base 0x01000, len 4, then 5 sample_clk edges -> voice0 addr 0x01000, 0x01001, 0x01002, 0x01003, then voice_active[0]=0 after the 4th edge; addr_sel 0 throughout.
REQ-037 Four note-ons, keys 1..4 -> voice_active=4'b1111, addr_sel=3; fifth note-on key 5 -> steals voice0 (age 3), voice_addr0 = new base.
REQ-038 Note-on key 7 twice with different bases -> the same voice is retriggered to the second base, and only one voice is active.
REQ-039 Note-off key 9 with no match -> key_ack pulses and voice_active is unchanged; note-off of a playing key clears only that voice.
REQ-040 sample_clk edge coincident with key_req -> ADVANCE first, then ALLOC; key_ack within 3 cycles; the new voice is not advanced by that edge.
REQ-041 Reset asserted during ALLOC -> no key_ack, all outputs 0 the next cycle, and the re-presented event is allocated to voice0.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: four-voice sample playback allocator with retrigger, steal and per-sample address advance
module voice_allocator #(
  parameter int ADDR_W = 20,
  parameter int KEY_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              sample_clk,
  input  logic              key_req,
  input  logic              key_on,
  input  logic [KEY_W-1:0]  key_code,
  input  logic [ADDR_W-1:0] key_base,
  input  logic [ADDR_W-1:0] key_len,
  output logic              key_ack,
  output logic [ADDR_W-1:0] voice_addr0,
  output logic [ADDR_W-1:0] voice_addr1,
  output logic [ADDR_W-1:0] voice_addr2,
  output logic [ADDR_W-1:0] voice_addr3,
  output logic [3:0]        voice_active,
  output logic [1:0]        addr_sel
);
  typedef enum logic [1:0] {IDLE, ADVANCE, ALLOC, RELEASE} state_t;
  state_t state_q, state_d;
  logic adv_pend_q, adv_pend_d, sclk_q, rise;
  logic [3:0][ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
  logic [3:0][KEY_W-1:0] key_q, key_d;
  logic [3:0][1:0] age_q, age_d;
  logic [3:0] active_q, active_d;
  logic [1:0] sel_q, sel_d;
  logic hit, free;
  logic [1:0] hit_idx, free_idx, old_idx, pick;
  logic [2:0] cnt;
  assign rise = sample_clk & ~sclk_q;
  // Victim choice: lowest-index retrigger match, else lowest free voice, else oldest (ties to lowest)
  always_comb begin
    hit = 1'b0;
    free = 1'b0;
    hit_idx = 2'd0;
    free_idx = 2'd0;
    old_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (active_q[i] && key_q[i] == key_code) begin
        hit = 1'b1;
        hit_idx = 2'(i);
      end
      if (!active_q[i]) begin
        free = 1'b1;
        free_idx = 2'(i);
      end
    end
    for (int i = 1; i < 4; i++)
      if (age_q[i] > age_q[old_idx]) old_idx = 2'(i);
    pick = hit ? hit_idx : free ? free_idx : old_idx;
  end
  // Next state; a sample edge seen in IDLE is serviced at once so it precedes a coincident key event
  always_comb begin
    state_d = IDLE;
    adv_pend_d = (adv_pend_q && state_q != ADVANCE) || rise;
    addr_d = addr_q;
    end_d = end_q;
    key_d = key_q;
    age_d = age_q;
    active_d = active_q;
    case (state_q)
      IDLE: state_d = (adv_pend_q || rise) ? ADVANCE : key_req ? (key_on ? ALLOC : RELEASE) : IDLE;
      ADVANCE:
        for (int i = 0; i < 4; i++)
          if (active_q[i]) begin
            if (addr_q[i] == end_q[i]) active_d[i] = 1'b0;
            else addr_d[i] = addr_q[i] + ADDR_W'(1);
          end
      ALLOC:
        for (int i = 0; i < 4; i++)
          if (2'(i) == pick) begin
            addr_d[i] = key_base;
            end_d[i] = key_base + key_len - ADDR_W'(1);
            key_d[i] = key_code;
            age_d[i] = 2'd0;
            active_d[i] = 1'b1;
          end else if (active_q[i] && age_q[i] != 2'd3) begin
            age_d[i] = age_q[i] + 2'd1;
          end
      RELEASE:
        for (int i = 0; i < 4; i++)
          if (key_q[i] == key_code) active_d[i] = 1'b0;
      default: state_d = IDLE;
    endcase
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) cnt = cnt + {2'b0, active_d[i]};
    sel_d = (cnt == 3'd0) ? 2'd0 : 2'(cnt - 3'd1);
  end
  // State and voice registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      adv_pend_q <= 1'b0;
      sclk_q <= 1'b0;
      addr_q <= '0;
      end_q <= '0;
      key_q <= '0;
      age_q <= '0;
      active_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      adv_pend_q <= adv_pend_d;
      sclk_q <= sample_clk;
      addr_q <= addr_d;
      end_q <= end_d;
      key_q <= key_d;
      age_q <= age_d;
      active_q <= active_d;
      sel_q <= sel_d;
    end
  end
  // Ack is suppressed while Reset is high so an aborted event is never acknowledged
  assign key_ack = ~Reset & (state_q == ALLOC || state_q == RELEASE);
  assign voice_addr0 = addr_q[0];
  assign voice_addr1 = addr_q[1];
  assign voice_addr2 = addr_q[2];
  assign voice_addr3 = addr_q[3];
  assign voice_active = active_q;
  assign addr_sel = sel_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scoreboard bench for voice_allocator
module tb_voice_allocator;
  logic Clk = 1'b0, Reset = 1'b1, sample_clk = 1'b0, key_req = 1'b0, key_on = 1'b0, key_ack;
  logic [7:0] key_code = '0;
  logic [19:0] key_base = '0, key_len = '0;
  logic [19:0] voice_addr0, voice_addr1, voice_addr2, voice_addr3;
  logic [3:0] voice_active;
  logic [1:0] addr_sel;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [3:0] act;
    logic [1:0] sel;
    logic [19:0] a0, a1, a2, a3;
  } exp_t;
  exp_t sb[$];

  voice_allocator dut (
    .Clk(Clk), .Reset(Reset), .sample_clk(sample_clk), .key_req(key_req), .key_on(key_on),
    .key_code(key_code), .key_base(key_base), .key_len(key_len), .key_ack(key_ack),
    .voice_addr0(voice_addr0), .voice_addr1(voice_addr1), .voice_addr2(voice_addr2),
    .voice_addr3(voice_addr3), .voice_active(voice_active), .addr_sel(addr_sel)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input exp_t e);
    chk({name, ".active"}, 32'(voice_active), 32'(e.act));
    chk({name, ".sel"}, 32'(addr_sel), 32'(e.sel));
    chk({name, ".addr0"}, 32'(voice_addr0), 32'(e.a0));
    chk({name, ".addr1"}, 32'(voice_addr1), 32'(e.a1));
    chk({name, ".addr2"}, 32'(voice_addr2), 32'(e.a2));
    chk({name, ".addr3"}, 32'(voice_addr3), 32'(e.a3));
  endtask

  // Monitor: each ack is followed, one cycle later, by the updated voice state
  initial forever begin
    @(negedge Clk);
    if (key_ack === 1'b1) begin
      @(negedge Clk);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got unexpected ack expected none");
      end else chk_state("event", sb.pop_front());
    end
  end

  task automatic key_event(input logic on, input logic [7:0] code, input logic [19:0] base,
                           input logic [19:0] len, input logic with_edge, input exp_t e);
    int n = 0;
    bit got = 0;
    @(negedge Clk);
    sb.push_back(e);
    key_on = on;
    key_code = code;
    key_base = base;
    key_len = len;
    key_req = 1'b1;
    if (with_edge) sample_clk = 1'b1;
    while (!got && n < 10) begin
      @(negedge Clk);
      n++;
      got = (key_ack === 1'b1);
    end
    key_req = 1'b0;
    chk("ack_latency", 32'(n), with_edge ? 32'd3 : 32'd1);
    repeat (10) @(negedge Clk);
    sample_clk = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic pulse_edge();
    @(negedge Clk);
    sample_clk = 1'b1;
    repeat (10) @(negedge Clk);
    sample_clk = 1'b0;
    repeat (10) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk_state("reset", '{4'b0000, 2'd0, 20'h0, 20'h0, 20'h0, 20'h0});
    chk("reset.ack", 32'(key_ack), 32'd0);
    // Single note playing through its four words
    key_event(1, 8'h3C, 20'h01000, 20'd4, 0, '{4'b0001, 2'd0, 20'h01000, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("adv1", '{4'b0001, 2'd0, 20'h01001, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("adv2", '{4'b0001, 2'd0, 20'h01002, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("adv3", '{4'b0001, 2'd0, 20'h01003, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("adv4", '{4'b0000, 2'd0, 20'h01003, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("adv5", '{4'b0000, 2'd0, 20'h01003, 20'h0, 20'h0, 20'h0});
    // Fill all voices, then steal the oldest
    do_reset();
    key_event(1, 8'd1, 20'h00100, 20'd16, 0, '{4'b0001, 2'd0, 20'h00100, 20'h0, 20'h0, 20'h0});
    key_event(1, 8'd2, 20'h00200, 20'd16, 0, '{4'b0011, 2'd1, 20'h00100, 20'h00200, 20'h0, 20'h0});
    key_event(1, 8'd3, 20'h00300, 20'd16, 0, '{4'b0111, 2'd2, 20'h00100, 20'h00200, 20'h00300, 20'h0});
    key_event(1, 8'd4, 20'h00400, 20'd16, 0, '{4'b1111, 2'd3, 20'h00100, 20'h00200, 20'h00300, 20'h00400});
    key_event(1, 8'd5, 20'h00500, 20'd16, 0, '{4'b1111, 2'd3, 20'h00500, 20'h00200, 20'h00300, 20'h00400});
    // Note-off without and with a match
    key_event(0, 8'd9, 20'h0, 20'd0, 0, '{4'b1111, 2'd3, 20'h00500, 20'h00200, 20'h00300, 20'h00400});
    key_event(0, 8'd3, 20'h0, 20'd0, 0, '{4'b1011, 2'd2, 20'h00500, 20'h00200, 20'h00300, 20'h00400});
    // Retrigger of the same key reuses its voice
    do_reset();
    key_event(1, 8'd7, 20'h00700, 20'd4, 0, '{4'b0001, 2'd0, 20'h00700, 20'h0, 20'h0, 20'h0});
    key_event(1, 8'd7, 20'h00780, 20'd4, 0, '{4'b0001, 2'd0, 20'h00780, 20'h0, 20'h0, 20'h0});
    key_event(0, 8'd7, 20'h0, 20'd0, 0, '{4'b0000, 2'd0, 20'h00780, 20'h0, 20'h0, 20'h0});
    // Address and end address wrap past all-ones
    key_event(1, 8'h20, 20'hFFFFE, 20'd3, 0, '{4'b0001, 2'd0, 20'hFFFFE, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("wrap1", '{4'b0001, 2'd0, 20'hFFFFF, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("wrap2", '{4'b0001, 2'd0, 20'h00000, 20'h0, 20'h0, 20'h0});
    pulse_edge(); chk_state("wrap3", '{4'b0000, 2'd0, 20'h00000, 20'h0, 20'h0, 20'h0});
    // Sample edge coincident with a note-on advances only the older voice
    do_reset();
    key_event(1, 8'h11, 20'h02000, 20'd100, 0, '{4'b0001, 2'd0, 20'h02000, 20'h0, 20'h0, 20'h0});
    key_event(1, 8'h12, 20'h03000, 20'd100, 1, '{4'b0011, 2'd1, 20'h02001, 20'h03000, 20'h0, 20'h0});
    // Reset during ALLOC aborts the event without ack
    @(negedge Clk);
    key_on = 1'b1;
    key_code = 8'h44;
    key_base = 20'h04444;
    key_len = 20'd5;
    key_req = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk("abort.ack", 32'(key_ack), 32'd0);
    key_req = 1'b0;
    @(negedge Clk);
    chk_state("abort", '{4'b0000, 2'd0, 20'h0, 20'h0, 20'h0, 20'h0});
    Reset = 1'b0;
    key_event(1, 8'h44, 20'h04444, 20'd5, 0, '{4'b0001, 2'd0, 20'h04444, 20'h0, 20'h0, 20'h0});
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
